ddr_wr_arbiter: RTL and testbench
=================================

DDR_WR_ARBITER -- requirements
Module: ddr_wr_arbiter

Interface
Parameters:
REQ-001 BURST_MAX, 10'd128, largest legal burst length in 64-bit beats.
REQ-002 TIMEOUT, 16'd4096, mem_clk cycles allowed from grant to m_burst_finish.
Ports:
REQ-003 mem_clk  in  1  clock for all logic.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 c0_wr_burst_req  in  1  channel 0 (frame writer) burst request.
REQ-006 c0_wr_burst_addr  in  27  channel 0 burst start address.
REQ-007 c0_wr_burst_len  in  10  channel 0 length in beats.
REQ-008 c0_wr_burst_data  in  64  channel 0 write data.
REQ-009 c0_wr_burst_data_req  out  1  channel 0 data strobe.
REQ-010 c0_burst_finish  out  1  channel 0 burst-complete pulse.
REQ-011 c1_* (req, addr, len, data, data_req, finish)  same widths and directions  channel 1 (overlay writer).
REQ-012 m_wr_burst_req / m_wr_burst_addr[26:0] / m_wr_burst_len[9:0] / m_wr_burst_data[63:0]  out  to memory controller.
REQ-013 m_wr_burst_data_req, m_burst_finish  in  1  from memory controller.
REQ-014 grant  out  2  one-hot owner; 2'b00 when idle.
REQ-015 err_timeout, err_len  out  1  single-cycle error pulses.

Function
REQ-016 FSM states: ARB_IDLE, ARB_REQ, ARB_BURST, ARB_END; reset state ARB_IDLE.
REQ-017 ARB_IDLE: with one request, grant that channel; with both, grant the channel not in last_grant (round-robin).
REQ-018 On grant, latch addr and len into m_wr_burst_addr/m_wr_burst_len, assert m_wr_burst_req, go ARB_REQ.
REQ-019 Latched len of 0 -> no memory request; 1-cycle finish pulse to the requester; go ARB_END.
REQ-020 Latched len > BURST_MAX -> clamp to BURST_MAX; err_len pulses for one cycle.
REQ-021 ARB_REQ: hold m_wr_burst_req high until the first m_wr_burst_data_req, drop it that cycle, go ARB_BURST.
REQ-022 m_wr_burst_data_req routes combinationally to the granted channel only; the other channel's data_req stays 0.
REQ-023 m_wr_burst_data is a combinational mux of the granted channel's data; requesters supply data one cycle after data_req.
REQ-024 A 10-bit beat counter counts data_req beats in ARB_REQ/ARB_BURST.
REQ-025 m_burst_finish in ARB_BURST forwards combinationally to the granted channel's finish; go ARB_END.
REQ-026 At finish, beat count != latched len -> err_len pulse.
REQ-027 ARB_END (one cycle): update last_grant, clear grant, go ARB_IDLE; requests are not sampled this cycle.
REQ-028 16-bit watchdog clears on grant and counts in ARB_REQ/ARB_BURST.
REQ-029 Watchdog reaching TIMEOUT -> err_timeout pulse, m_wr_burst_req low, finish pulse to owner, go ARB_END.
REQ-030 m_burst_finish outside ARB_BURST is ignored.
REQ-031 Requests arriving during a burst wait; a request is never dropped while asserted.

Reset
REQ-032 On rst_n low, all outputs reset to 0, state ARB_IDLE, counters 0, last_grant = channel 1 (channel 0 wins first tie).
REQ-033 Reset mid-burst aborts immediately; no finish pulse is produced.

Structure
REQ-034 Shared package holds the FSM state encodings (3-bit), BURST_MAX default and the 27-bit address width constant.
REQ-035 One sub-module, ddr_wr_rr_pick (2-way round-robin selector: req[1:0], last_grant -> one-hot grant); all else flat.

Verification
REQ-036 c0 only, len=16: m_wr_burst_req rises, 16 data_req routed to c0, c0 finish pulse, grant back to 00, err pulses 0.
REQ-037 c0 and c1 request together, len=8 each, from reset: c0 served first, then c1; repeated tie alternates c0/c1.
REQ-038 c1 len=0: no m_wr_burst_req; c1_burst_finish pulses within 2 cycles.
REQ-039 c0 len=200: m_wr_burst_len=128; err_len pulses once.
REQ-040 Controller never raises finish: err_timeout pulses at 4096 cycles; arbiter returns to ARB_IDLE and serves pending c1.
REQ-041 rst_n low mid-burst (beat 5 of 32): all outputs 0 next edge; a fresh c1 request after release is served normally.

Source files
------------

// File: rtl/ddr_wr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the DDR write-burst arbiter.
package ddr_wr_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 64;

  localparam logic [LEN_W-1:0] BURST_MAX_DEFAULT = 10'd128;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_REQ   = 3'd1,
    ARB_BURST = 3'd2,
    ARB_END   = 3'd3
  } arb_state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ddr_wr_rr_pick.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the channel
// that did not own the bus last.
module ddr_wr_rr_pick
  import ddr_wr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Two-channel DDR write-burst arbiter: round-robin ownership of one memory
// controller port with length clamping, beat accounting and a watchdog.
module ddr_wr_arbiter
  import ddr_wr_arbiter_pkg::*;
#(
  parameter logic [LEN_W-1:0] BURST_MAX = BURST_MAX_DEFAULT,
  parameter logic [15:0]      TIMEOUT   = 16'd4096
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              c0_wr_burst_req,
  input  logic [ADDR_W-1:0] c0_wr_burst_addr,
  input  logic [LEN_W-1:0]  c0_wr_burst_len,
  input  logic [DATA_W-1:0] c0_wr_burst_data,
  output logic              c0_wr_burst_data_req,
  output logic              c0_burst_finish,
  input  logic              c1_wr_burst_req,
  input  logic [ADDR_W-1:0] c1_wr_burst_addr,
  input  logic [LEN_W-1:0]  c1_wr_burst_len,
  input  logic [DATA_W-1:0] c1_wr_burst_data,
  output logic              c1_wr_burst_data_req,
  output logic              c1_burst_finish,
  output logic              m_wr_burst_req,
  output logic [ADDR_W-1:0] m_wr_burst_addr,
  output logic [LEN_W-1:0]  m_wr_burst_len,
  output logic [DATA_W-1:0] m_wr_burst_data,
  input  logic              m_wr_burst_data_req,
  input  logic              m_burst_finish,
  output logic [1:0]        grant,
  output logic              err_timeout,
  output logic              err_len
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              m_req_q, m_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [15:0]       wd_q, wd_d;
  logic              fin_pulse_q, fin_pulse_d;
  logic              err_len_q, err_len_d;
  logic              err_to_q, err_to_d;

  logic [1:0]        pick_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  beat_inc;
  logic [15:0]       wd_inc;
  logic              burst_active;
  logic              fwd_finish;

  ddr_wr_rr_pick u_pick (
    .req        ({c1_wr_burst_req, c0_wr_burst_req}),
    .last_grant (last_grant_q),
    .grant      (pick_grant)
  );

  assign sel_addr     = pick_grant[0] ? c0_wr_burst_addr : c1_wr_burst_addr;
  assign sel_len      = pick_grant[0] ? c0_wr_burst_len  : c1_wr_burst_len;
  assign beat_inc     = beat_q + LEN_W'(m_wr_burst_data_req);
  assign wd_inc       = wd_q + 16'd1;
  assign burst_active = (state_q == ARB_REQ) || (state_q == ARB_BURST);
  assign fwd_finish   = (state_q == ARB_BURST) && m_burst_finish;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    wd_d         = wd_q;
    fin_pulse_d  = 1'b0;
    err_len_d    = 1'b0;
    err_to_d     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|pick_grant) begin
          grant_d   = pick_grant;
          addr_d    = sel_addr;
          len_d     = clamp_len(sel_len, BURST_MAX);
          err_len_d = (sel_len > BURST_MAX);
          beat_d    = '0;
          wd_d      = '0;
          // An empty burst never reaches the controller; the requester is released at once.
          if (sel_len == '0) begin
            fin_pulse_d = 1'b1;
            state_d     = ARB_END;
          end else begin
            m_req_d = 1'b1;
            state_d = ARB_REQ;
          end
        end
      end
      ARB_REQ: begin
        beat_d = beat_inc;
        wd_d   = wd_inc;
        if (wd_inc == TIMEOUT) begin
          err_to_d    = 1'b1;
          m_req_d     = 1'b0;
          fin_pulse_d = 1'b1;
          state_d     = ARB_END;
        end else if (m_wr_burst_data_req) begin
          m_req_d = 1'b0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        beat_d = beat_inc;
        wd_d   = wd_inc;
        // A real finish wins over a watchdog expiry landing on the same cycle.
        if (m_burst_finish) begin
          err_len_d = (beat_inc != len_q);
          state_d   = ARB_END;
        end else if (wd_inc == TIMEOUT) begin
          err_to_d    = 1'b1;
          fin_pulse_d = 1'b1;
          state_d     = ARB_END;
        end
      end
      ARB_END: begin
        last_grant_d = grant_q[1];
        grant_d      = 2'b00;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      m_req_q      <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      fin_pulse_q  <= 1'b0;
      err_len_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      fin_pulse_q  <= fin_pulse_d;
      err_len_q    <= err_len_d;
      err_to_q     <= err_to_d;
    end
  end

  assign grant           = grant_q;
  assign m_wr_burst_req  = m_req_q;
  assign m_wr_burst_addr = addr_q;
  assign m_wr_burst_len  = len_q;
  assign err_len         = err_len_q;
  assign err_timeout     = err_to_q;

  assign m_wr_burst_data = grant_q[0] ? c0_wr_burst_data :
                           grant_q[1] ? c1_wr_burst_data : '0;

  assign c0_wr_burst_data_req = burst_active && grant_q[0] && m_wr_burst_data_req;
  assign c1_wr_burst_data_req = burst_active && grant_q[1] && m_wr_burst_data_req;
  assign c0_burst_finish      = grant_q[0] && (fwd_finish || fin_pulse_q);
  assign c1_burst_finish      = grant_q[1] && (fwd_finish || fin_pulse_q);

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Bench for ddr_wr_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of ownership, beats and error pulses.
module tb_ddr_wr_arbiter;

  localparam int BMAX = 128;
  localparam int TMO  = 4096;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        ch_req  [2];
  logic [26:0] ch_addr [2];
  logic [9:0]  ch_len  [2];
  logic [63:0] ch_data [2];
  logic        c0_wr_burst_data_req, c0_burst_finish;
  logic        c1_wr_burst_data_req, c1_burst_finish;
  logic        m_wr_burst_req;
  logic [26:0] m_wr_burst_addr;
  logic [9:0]  m_wr_burst_len;
  logic [63:0] m_wr_burst_data;
  logic        m_wr_burst_data_req = 1'b0;
  logic        m_burst_finish = 1'b0;
  logic [1:0]  grant;
  logic        err_timeout, err_len;

  ddr_wr_arbiter dut (
    .mem_clk              (mem_clk),
    .rst_n                (rst_n),
    .c0_wr_burst_req      (ch_req[0]),
    .c0_wr_burst_addr     (ch_addr[0]),
    .c0_wr_burst_len      (ch_len[0]),
    .c0_wr_burst_data     (ch_data[0]),
    .c0_wr_burst_data_req (c0_wr_burst_data_req),
    .c0_burst_finish      (c0_burst_finish),
    .c1_wr_burst_req      (ch_req[1]),
    .c1_wr_burst_addr     (ch_addr[1]),
    .c1_wr_burst_len      (ch_len[1]),
    .c1_wr_burst_data     (ch_data[1]),
    .c1_wr_burst_data_req (c1_wr_burst_data_req),
    .c1_burst_finish      (c1_burst_finish),
    .m_wr_burst_req       (m_wr_burst_req),
    .m_wr_burst_addr      (m_wr_burst_addr),
    .m_wr_burst_len       (m_wr_burst_len),
    .m_wr_burst_data      (m_wr_burst_data),
    .m_wr_burst_data_req  (m_wr_burst_data_req),
    .m_burst_finish       (m_burst_finish),
    .grant                (grant),
    .err_timeout          (err_timeout),
    .err_len              (err_len)
  );

  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: who owns the bus, whether the first beat is still awaited,
  // how many beats/cycles have elapsed, and which pulses are due this cycle.
  int          owner, last, elapsed, beats, lat_len, granted_now;
  logic [26:0] lat_addr;
  bit          waiting, bursting, ending, end_fin, e_len, e_to;

  // Controller / requester stimulus state.
  bit c_started, hang0, rand_mode, short_en, spur_en;
  int c_gap, c_left, c_fwait;
  int issued [2];
  int served [2];

  // Observations of DUT outputs for the directed literal checks.
  int         ob_dreq [2];
  int         ob_fin  [2];
  int         ob_err_len, ob_err_to, ob_mreq_rose, grant_age, to_age;
  logic [1:0] grant_hist [$];
  logic [1:0] prev_g;
  logic       prev_mreq;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    owner = -1; last = 1; elapsed = 0; beats = 0; lat_len = 0; lat_addr = '0;
    waiting = 0; bursting = 0; ending = 0; end_fin = 0; e_len = 0; e_to = 0;
    granted_now = -1;
  endtask

  task automatic model_step();
    int lenin;
    bit was_burst;
    granted_now = -1; e_len = 0; e_to = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (ending) begin
      last = owner; owner = -1; ending = 0; end_fin = 0;
    end else if (owner < 0) begin
      if (ch_req[0] || ch_req[1]) begin
        if (ch_req[0] && ch_req[1]) owner = (last == 0) ? 1 : 0;
        else owner = ch_req[0] ? 0 : 1;
        granted_now = owner;
        lenin    = int'(ch_len[owner]);
        lat_addr = ch_addr[owner];
        lat_len  = (lenin > BMAX) ? BMAX : lenin;
        e_len    = (lenin > BMAX);
        elapsed  = 0; beats = 0;
        if (lenin == 0) begin ending = 1; end_fin = 1; end
        else waiting = 1;
      end
    end else begin
      was_burst = bursting;
      elapsed++;
      if (m_wr_burst_data_req) beats++;
      if (waiting && m_wr_burst_data_req) begin waiting = 0; bursting = 1; end
      if (was_burst && m_burst_finish) begin
        e_len = (beats != lat_len);
        bursting = 0; ending = 1; end_fin = 0;
      end else if (elapsed == TMO) begin
        e_to = 1; waiting = 0; bursting = 0; ending = 1; end_fin = 1;
      end
    end
  endtask

  function automatic logic [8:0] exp_ctrl();
    bit act, f0, f1;
    logic [1:0] g;
    act = waiting || bursting;
    g   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    f0  = (owner == 0) && ((bursting && m_burst_finish) || (ending && end_fin));
    f1  = (owner == 1) && ((bursting && m_burst_finish) || (ending && end_fin));
    return {g, waiting, act && owner == 0 && m_wr_burst_data_req,
            act && owner == 1 && m_wr_burst_data_req, f0, f1, e_len, e_to};
  endfunction

  task automatic issue(input int ch, input logic [26:0] a, input logic [9:0] l);
    ch_req[ch] = 1'b1; ch_addr[ch] = a; ch_len[ch] = l; issued[ch]++;
  endtask

  task automatic ctrl_step();
    m_wr_burst_data_req = 1'b0;
    m_burst_finish      = 1'b0;
    if (waiting || bursting) begin
      if (!c_started) begin
        c_started = 1;
        c_gap     = $urandom_range(0, 3);
        c_fwait   = $urandom_range(0, 3);
        c_left    = lat_len;
        if (short_en && lat_len >= 2 && $urandom_range(0, 5) == 0) c_left = lat_len - 1;
        else if (short_en && $urandom_range(0, 5) == 0) c_left = lat_len + 1;
      end
      if (c_gap > 0) begin
        c_gap--;
        m_burst_finish = spur_en && ($urandom_range(0, 3) == 0);
      end else if (c_left > 0) begin
        if ($urandom_range(0, 3) != 0) begin m_wr_burst_data_req = 1'b1; c_left--; end
      end else if (!(hang0 && owner == 0)) begin
        if (c_fwait > 0) c_fwait--;
        else m_burst_finish = 1'b1;
      end
    end else begin
      c_started = 0;
      m_burst_finish = spur_en && ($urandom_range(0, 15) == 0);
    end
  endtask

  function automatic logic [9:0] rand_len();
    if ($urandom_range(0, 7) == 0) return 10'd0;
    if ($urandom_range(0, 7) == 0) return 10'($urandom_range(129, 300));
    return 10'($urandom_range(1, 40));
  endfunction

  task automatic drive_step();
    for (int ch = 0; ch < 2; ch++) begin
      ch_data[ch] = {$urandom, $urandom};
      if (granted_now == ch) begin
        ch_req[ch] = 1'b0;
        served[ch]++;
      end else if (rand_mode && !ch_req[ch] && $urandom_range(0, 5) == 0) begin
        issue(ch, 27'($urandom), rand_len());
      end
    end
    ctrl_step();
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
    drive_step();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    while ((ch_req[0] || ch_req[1] || owner >= 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", tag, budget);
    end
    tick();
    tick();
  endtask

  task automatic clear_obs();
    ob_dreq[0] = 0; ob_dreq[1] = 0; ob_fin[0] = 0; ob_fin[1] = 0;
    ob_err_len = 0; ob_err_to = 0; ob_mreq_rose = 0; to_age = -1;
    grant_hist.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Model advances on every active edge, using the inputs the DUT sampled there.
  initial forever begin
    @(posedge mem_clk);
    model_step();
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  initial begin
    prev_g = 2'b00; prev_mreq = 1'b0; grant_age = 0;
    forever begin
      @(negedge mem_clk);
      check("ctrl_bits", {grant, m_wr_burst_req, c0_wr_burst_data_req, c1_wr_burst_data_req,
                          c0_burst_finish, c1_burst_finish, err_len, err_timeout}, exp_ctrl());
      check("addr_len", {m_wr_burst_addr, m_wr_burst_len}, {lat_addr, 10'(lat_len)});
      check("wr_data", m_wr_burst_data,
            (owner == 0) ? ch_data[0] : (owner == 1) ? ch_data[1] : 64'd0);
      if (c0_wr_burst_data_req) ob_dreq[0]++;
      if (c1_wr_burst_data_req) ob_dreq[1]++;
      if (c0_burst_finish) ob_fin[0]++;
      if (c1_burst_finish) ob_fin[1]++;
      if (err_len) ob_err_len++;
      if (m_wr_burst_req && !prev_mreq) ob_mreq_rose++;
      if (grant != 2'b00) begin
        if (prev_g == 2'b00) begin
          grant_age = 0;
          grant_hist.push_back(grant);
        end else grant_age++;
      end
      if (err_timeout) begin ob_err_to++; to_age = grant_age; end
      prev_g = grant; prev_mreq = m_wr_burst_req;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: bench did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] exp_hist [4];
    int n;
    exp_hist[0] = 2'b01; exp_hist[1] = 2'b10; exp_hist[2] = 2'b01; exp_hist[3] = 2'b10;
    rst_n = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      ch_req[ch] = 1'b0; ch_addr[ch] = '0; ch_len[ch] = '0; ch_data[ch] = '0;
      issued[ch] = 0; served[ch] = 0;
    end
    hang0 = 0; rand_mode = 0; short_en = 0; spur_en = 0; c_started = 0;
    model_reset();
    clear_obs();
    repeat (3) tick();
    @(negedge mem_clk);
    check("reset_outputs", {grant, m_wr_burst_req, err_len, err_timeout, c0_burst_finish,
                            c1_burst_finish, m_wr_burst_len}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single c0 burst of 16 beats.
    clear_obs();
    issue(0, 27'h1234567, 10'd16);
    wait_quiet(500, "t1_wait");
    check("t1_c0_beats", ob_dreq[0], 16);
    check("t1_c1_beats", ob_dreq[1], 0);
    check("t1_c0_finish", ob_fin[0], 1);
    check("t1_mreq_rose", ob_mreq_rose, 1);
    check("t1_errs", ob_err_len + ob_err_to, 0);
    check("t1_addr", m_wr_burst_addr, 27'h1234567);
    check("t1_grant_idle", grant, 2'b00);

    // Simultaneous requests from reset: c0 first, then alternation on a repeated tie.
    do_reset();
    tick();
    clear_obs();
    issue(0, 27'h0000100, 10'd8);
    issue(1, 27'h0000200, 10'd8);
    wait_quiet(500, "t2_wait_a");
    issue(0, 27'h0000300, 10'd8);
    issue(1, 27'h0000400, 10'd8);
    wait_quiet(500, "t2_wait_b");
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_order%0d", i), (i < grant_hist.size()) ? grant_hist[i] : 2'b11,
            exp_hist[i]);

    // Zero-length c1 burst.
    clear_obs();
    issue(1, 27'h0000500, 10'd0);
    tick();
    tick();
    check("t3_c1_finish_fast", ob_fin[1], 1);
    wait_quiet(50, "t3_wait");
    check("t3_no_mreq", ob_mreq_rose, 0);
    check("t3_one_finish", ob_fin[1], 1);

    // Over-long burst clamps to 128 beats.
    clear_obs();
    issue(0, 27'h0000600, 10'd200);
    tick();
    tick();
    check("t4_len_clamped", m_wr_burst_len, 10'd128);
    wait_quiet(800, "t4_wait");
    check("t4_err_len_once", ob_err_len, 1);
    check("t4_beats", ob_dreq[0], 128);

    // Controller never finishes: watchdog fires, pending c1 is then served.
    clear_obs();
    hang0 = 1;
    issue(0, 27'h0000700, 10'd16);
    tick();
    issue(1, 27'h0000800, 10'd8);
    wait_quiet(6000, "t5_wait");
    hang0 = 0;
    check("t5_err_timeout_once", ob_err_to, 1);
    check("t5_timeout_cycles", to_age, TMO);
    check("t5_c0_finish", ob_fin[0], 1);
    check("t5_c1_finish", ob_fin[1], 1);
    check("t5_c1_served", (grant_hist.size() > 1) ? grant_hist[1] : 2'b11, 2'b10);

    // Reset in the middle of a 32-beat burst.
    clear_obs();
    issue(0, 27'h0000900, 10'd32);
    n = 0;
    while (ob_dreq[0] < 5 && n < 300) begin tick(); n++; end
    check("t6_reached_beat5", ob_dreq[0], 5);
    rst_n = 1'b0;
    model_reset();
    @(negedge mem_clk);
    check("t6_outputs_zero", {grant, m_wr_burst_req, m_wr_burst_addr, m_wr_burst_len,
                              m_wr_burst_data, c0_wr_burst_data_req, c1_wr_burst_data_req,
                              c0_burst_finish, c1_burst_finish, err_len, err_timeout}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_c0_finish", ob_fin[0], 0);
    issue(1, 27'h0000A00, 10'd8);
    wait_quiet(300, "t6_wait");
    check("t6_c1_beats", ob_dreq[1], 8);
    check("t6_c1_finish", ob_fin[1], 1);

    // Randomized traffic with short/long beat counts and stray finishes.
    clear_obs();
    issued[0] = 0; issued[1] = 0; served[0] = 0; served[1] = 0;
    rand_mode = 1; short_en = 1; spur_en = 1;
    repeat (15000) tick();
    rand_mode = 0;
    wait_quiet(2000, "t7_wait");
    spur_en = 0;
    check("t7_served_c0", served[0], issued[0]);
    check("t7_served_c1", served[1], issued[1]);
    check("t7_finish_c0", ob_fin[0], served[0]);
    check("t7_finish_c1", ob_fin[1], served[1]);
    check("t7_no_timeout", ob_err_to, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
